// File: rtl/stream_fifo_v3.sv
// Single-clock valid/ready stream FIFO with fill-level output and optional fall-through.
// DEPTH = 0 turns the block into a combinational pass-through with no state.
module stream_fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    if (DEPTH == 0) begin : g_passthru
        assign data_o  = data_i;
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign usage_o = '0;

        logic unused_passthru;
        assign unused_passthru = ^{clk_i, rst_i, flush_i, testmode_i};
    end else begin : g_fifo
        localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);
        localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

        logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
        logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
        logic [ADDR_DEPTH:0]   count_q, count_d;
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        logic full, empty, push, pop;
        logic ft_active, bypass, mem_we;

        logic unused_testmode;
        assign unused_testmode = testmode_i;

        assign full      = (count_q == FULL_CNT);
        // Fall-through view: an empty FIFO presents the incoming element directly.
        assign ft_active = FALL_THROUGH && (count_q == '0) && valid_i;
        assign bypass    = ft_active && ready_i;
        assign empty     = (count_q == '0) && !ft_active;

        assign ready_o = ~full;
        assign valid_o = ~empty;
        assign push    = valid_i && !full;
        assign pop     = ready_i && !empty;
        assign mem_we  = push && !bypass && !flush_i;

        assign data_o  = ft_active ? data_i : mem_q[rd_ptr_q];
        assign usage_o = count_q[ADDR_DEPTH-1:0];

        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;

            if (flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else if (!bypass) begin
                if (push) begin
                    wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                end
                if (push && !pop) begin
                    count_d = count_q + 1'b1;
                end else if (pop && !push) begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // NOTE: storage is cleared on reset so data_o reads a defined 0 afterwards; flush leaves it alone.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem_q[i] <= '0;
                end
            end else if (mem_we) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo_v3.sv
// Directed scoreboard bench for stream_fifo_v3 across depth 4, 3, 2 (with and without
// fall-through) and the depth-0 pass-through.
module tb_stream_fifo_v3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Depth 4, registered output
    logic       d4_flush, d4_valid, d4_ready, d4_ready_o, d4_valid_o;
    logic [7:0] d4_data, d4_data_o;
    logic [1:0] d4_usage;
    // Depth 3, registered output
    logic       d3_valid, d3_ready, d3_ready_o, d3_valid_o;
    logic [7:0] d3_data, d3_data_o;
    logic [1:0] d3_usage;
    // Depth 2, fall-through
    logic       ft_valid, ft_ready, ft_ready_o, ft_valid_o;
    logic [7:0] ft_data, ft_data_o;
    logic [0:0] ft_usage;
    // Depth 2, registered output
    logic       d2_valid, d2_ready, d2_ready_o, d2_valid_o;
    logic [7:0] d2_data, d2_data_o;
    logic [0:0] d2_usage;
    // Depth 0 pass-through
    logic       d0_valid, d0_ready, d0_ready_o, d0_valid_o;
    logic [7:0] d0_data, d0_data_o;
    logic [0:0] d0_usage;

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_i(rst), .flush_i(d4_flush), .testmode_i(1'b0), .usage_o(d4_usage),
        .data_i(d4_data), .valid_i(d4_valid), .ready_o(d4_ready_o),
        .data_o(d4_data_o), .valid_o(d4_valid_o), .ready_i(d4_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b0), .usage_o(d3_usage),
        .data_i(d3_data), .valid_i(d3_valid), .ready_o(d3_ready_o),
        .data_o(d3_data_o), .valid_o(d3_valid_o), .ready_i(d3_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(2)) u_ft (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b0), .usage_o(ft_usage),
        .data_i(ft_data), .valid_i(ft_valid), .ready_o(ft_ready_o),
        .data_o(ft_data_o), .valid_o(ft_valid_o), .ready_i(ft_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b0), .usage_o(d2_usage),
        .data_i(d2_data), .valid_i(d2_valid), .ready_o(d2_ready_o),
        .data_o(d2_data_o), .valid_o(d2_valid_o), .ready_i(d2_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_d0 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b0), .usage_o(d0_usage),
        .data_i(d0_data), .valid_i(d0_valid), .ready_o(d0_ready_o),
        .data_o(d0_data_o), .valid_o(d0_valid_o), .ready_i(d0_ready));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sb4[$];
    logic [7:0] sb3[$];
    logic [7:0] fill_vals[4];
    int         model_cnt4;

    initial begin
        fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
        d4_flush = 0; d4_valid = 0; d4_ready = 0; d4_data = 0;
        d3_valid = 0; d3_ready = 0; d3_data = 0;
        ft_valid = 0; ft_ready = 0; ft_data = 0;
        d2_valid = 0; d2_ready = 0; d2_data = 0;
        d0_valid = 0; d0_ready = 0; d0_data = 0;
        model_cnt4 = 0;

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(d4_valid_o), 32'd0);
        check("rst_ready", 32'(d4_ready_o), 32'd1);
        check("rst_usage", 32'(d4_usage), 32'd0);
        check("rst_data", 32'(d4_data_o), 32'd0);
        check("rst_d3_ready", 32'(d3_ready_o), 32'd1);

        // Fill depth 4 with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            d4_valid = 1'b1; d4_data = fill_vals[i]; d4_ready = 1'b0;
            #1;
            check("fill_ready", 32'(d4_ready_o), 32'd1);
            sb4.push_back(fill_vals[i]);
            model_cnt4++;
            tick();
            check("fill_usage", 32'(d4_usage), 32'(model_cnt4 % 4));
        end
        check("full_ready", 32'(d4_ready_o), 32'd0);
        check("full_valid", 32'(d4_valid_o), 32'd1);

        // Fifth element refused
        d4_valid = 1'b1; d4_data = 8'h55;
        #1;
        check("refuse_ready", 32'(d4_ready_o), 32'd0);
        tick();
        d4_valid = 1'b0;
        #1;
        check("refuse_usage", 32'(d4_usage), 32'd0);
        check("refuse_still_full", 32'(d4_ready_o), 32'd0);

        // Drain in order
        d4_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", 32'(d4_valid_o), 32'd1);
            check("drain_data", 32'(d4_data_o), 32'(sb4.pop_front()));
            tick();
        end
        check("drained_valid", 32'(d4_valid_o), 32'd0);
        check("drained_usage", 32'(d4_usage), 32'd0);
        check("drained_ready", 32'(d4_ready_o), 32'd1);
        d4_ready = 1'b0;

        // Depth 3 wrap-around with simultaneous push and pop
        d3_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                d3_valid = 1'b1; d3_data = 8'(k);
                sb3.push_back(8'(k));
            end else begin
                d3_valid = 1'b0;
            end
            #1;
            if (k > 0) begin
                check("wrap_valid", 32'(d3_valid_o), 32'd1);
                check("wrap_data", 32'(d3_data_o), 32'(sb3.pop_front()));
                check("wrap_usage", 32'(d3_usage), 32'd1);
            end
            tick();
        end
        check("wrap_end_valid", 32'(d3_valid_o), 32'd0);
        check("wrap_end_usage", 32'(d3_usage), 32'd0);
        d3_ready = 1'b0;

        // Fall-through bypass on empty FIFO
        ft_valid = 1'b1; ft_data = 8'hAB; ft_ready = 1'b1;
        #1;
        check("ft_valid", 32'(ft_valid_o), 32'd1);
        check("ft_data", 32'(ft_data_o), 32'hAB);
        tick();
        ft_valid = 1'b0;
        #1;
        check("ft_usage_after", 32'(ft_usage), 32'd0);
        check("ft_valid_after", 32'(ft_valid_o), 32'd0);

        // Fall-through with stalled consumer stores the element
        ft_valid = 1'b1; ft_data = 8'hCD; ft_ready = 1'b0;
        #1;
        check("ft_stall_data", 32'(ft_data_o), 32'hCD);
        tick();
        ft_valid = 1'b0;
        #1;
        check("ft_stored_usage", 32'(ft_usage), 32'd1);
        check("ft_stored_data", 32'(ft_data_o), 32'hCD);
        ft_ready = 1'b1;
        tick();
        check("ft_popped_usage", 32'(ft_usage), 32'd0);
        ft_ready = 1'b0;

        // Depth 2 full, pop and refused push in the same cycle
        d2_valid = 1'b1; d2_data = 8'hA1; d2_ready = 1'b0;
        tick();
        d2_data = 8'hB2;
        tick();
        check("d2_full_ready", 32'(d2_ready_o), 32'd0);
        check("d2_full_usage", 32'(d2_usage), 32'd0);
        d2_data = 8'hC3; d2_ready = 1'b1;
        #1;
        check("d2_pop_ready", 32'(d2_ready_o), 32'd0);
        check("d2_pop_data", 32'(d2_data_o), 32'hA1);
        tick();
        d2_valid = 1'b0;
        #1;
        check("d2_after_ready", 32'(d2_ready_o), 32'd1);
        check("d2_after_usage", 32'(d2_usage), 32'd1);
        check("d2_after_data", 32'(d2_data_o), 32'hB2);
        tick();
        check("d2_c_dropped", 32'(d2_valid_o), 32'd0);
        d2_ready = 1'b0;

        // Flush with concurrent push on depth 4
        d4_valid = 1'b1; d4_data = 8'h61;
        tick();
        d4_data = 8'h62;
        tick();
        d4_valid = 1'b0;
        #1;
        check("pre_flush_usage", 32'(d4_usage), 32'd2);
        d4_flush = 1'b1; d4_valid = 1'b1; d4_data = 8'h63;
        tick();
        d4_flush = 1'b0; d4_valid = 1'b0;
        #1;
        check("flush_valid", 32'(d4_valid_o), 32'd0);
        check("flush_usage", 32'(d4_usage), 32'd0);
        check("flush_ready", 32'(d4_ready_o), 32'd1);
        d4_valid = 1'b1; d4_data = 8'h70;
        tick();
        d4_valid = 1'b0;
        #1;
        check("post_flush_data", 32'(d4_data_o), 32'h70);
        check("post_flush_usage", 32'(d4_usage), 32'd1);

        // Reset mid-stream clears storage
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst2_valid", 32'(d4_valid_o), 32'd0);
        check("rst2_data", 32'(d4_data_o), 32'd0);
        check("rst2_usage", 32'(d4_usage), 32'd0);

        // Depth 0 pass-through
        d0_data = 8'h5A; d0_valid = 1'b1; d0_ready = 1'b0;
        #1;
        check("pt_data", 32'(d0_data_o), 32'h5A);
        check("pt_valid", 32'(d0_valid_o), 32'd1);
        check("pt_ready", 32'(d0_ready_o), 32'd0);
        check("pt_usage", 32'(d0_usage), 32'd0);
        d0_data = 8'hA5; d0_valid = 1'b0; d0_ready = 1'b1;
        #1;
        check("pt_data2", 32'(d0_data_o), 32'hA5);
        check("pt_valid2", 32'(d0_valid_o), 32'd0);
        check("pt_ready2", 32'(d0_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo_v3.md
# stream_fifo_v3

Parameterisable single-clock FIFO with a valid/ready stream interface on both sides and a fill-level output. It buffers elements between a producer and a consumer, for example per-bank request and response buffering in a memory splitter. An optional fall-through mode gives zero-cycle latency. Depth 0 degenerates to a combinational pass-through.

## Interface
Parameters:
- FALL_THROUGH, 0: when 1, an element pushed into an empty FIFO appears on data_o in the same cycle.
- DATA_WIDTH, 32: element width in bits (≥1).
- DEPTH, 8: number of storage entries; 0 means pass-through with no storage.
- ADDR_DEPTH, derived: (DEPTH > 1) ? $clog2(DEPTH) : 1; not to be overridden.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous clear of all content.
- testmode_i  in  1  test-mode bypass; no functional effect.
- usage_o  out  ADDR_DEPTH  current fill level, modulo 2^ADDR_DEPTH.
- data_i  in  DATA_WIDTH  input element.
- valid_i  in  1  input element valid.
- ready_o  out  1  FIFO can accept an element (not full).
- data_o  out  DATA_WIDTH  head element.
- valid_o  out  1  head element valid (not empty).
- ready_i  in  1  consumer accepts the head element.

## Operation
- State: write pointer, read pointer, count (ADDR_DEPTH+1 bits), memory of DEPTH × DATA_WIDTH.
- full = (count == DEPTH).
- ready_o = ~full.
- push = valid_i & ready_o.
- empty = (count == 0) & ~(FALL_THROUGH & valid_i).
- valid_o = ~empty.
- pop = ready_i & valid_o.
- data_o = mem[read pointer], except FALL_THROUGH & count == 0 & valid_i, where data_o = data_i.
- Push: write data_i at the write pointer, then advance the pointer. Pointers wrap from DEPTH-1 to 0, so non-power-of-two depths are legal.
- Pop: advance the read pointer.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged, with the write and the read both performed.
- Fall-through bypass: FALL_THROUGH, count == 0, valid_i and ready_i all high means the element passes through directly. Nothing is written, and pointers and count are unchanged.
- Valid_i while full is not accepted: ready_o is low and nothing is written, even if a pop occurs that cycle. ready_o rises the cycle after the pop.
- Ready_i while empty has no effect.
- flush_i has priority over push and pop. Next cycle: pointers = 0, count = 0. Memory contents are left as is.
- rst_i has priority over flush_i. Next cycle: pointers, count and all memory entries = 0.
- DEPTH == 0: data_o = data_i, valid_o = valid_i, ready_o = ready_i, usage_o = 0. No state is held.
- usage_o = count[ADDR_DEPTH-1:0]. When DEPTH is a power of two ≥2 and the FIFO is full, usage_o reads 0; full is indicated by ready_o = 0.

## Timing
- Register values one clock after rst_i is sampled high:
  - pointers = 0, count = 0, memory all 0.
- Output values one clock after rst_i is sampled high:
  - valid_o = 0 and usage_o = 0.
  - ready_o = 1 (DEPTH > 0).
  - data_o = 0, or data_i under the fall-through condition.
- Before the first reset edge, outputs are undefined.
- Non-fall-through latency: an element accepted at edge N is on data_o with valid_o = 1 after edge N (1 cycle).
- Fall-through latency: 0 cycles when empty.
- ready_o and usage_o depend only on registered state; they have no combinational path from valid_i or ready_i (DEPTH > 0).
- valid_o and data_o depend combinationally on valid_i and data_i only when FALL_THROUGH = 1.
- Throughput: one push and one pop per cycle, sustained.
- Reset or flush asserted mid-stream discards all content; elements pushed in that same cycle are lost.

## Test plan
- Reset and fill: DEPTH = 4, FALL_THROUGH = 0, reset, then push 0x11, 0x22, 0x33, 0x44 with ready_i = 0.
  - After reset: valid_o = 0, ready_o = 1, usage_o = 0.
  - After the pushes: ready_o = 0 and usage_o = 0 (wrap at 4 entries).
  - Fifth valid_i is refused.
- Drain and order: from the full state above, raise ready_i.
  - data_o sequence is 0x11, 0x22, 0x33, 0x44, one per cycle.
  - Then valid_o = 0 and usage_o = 0.
- Wrap-around, non-power-of-two: DEPTH = 3, continuous push and pop for 10 elements 0..9 with simultaneous handshakes.
  - Output order is 0..9 and the count stays constant.
- Fall-through: FALL_THROUGH = 1, DEPTH = 2, empty, valid_i = 1, data_i = 0xAB, ready_i = 1.
  - Same cycle: valid_o = 1, data_o = 0xAB.
  - Next cycle: usage_o = 0 and nothing is stored.
- Full with simultaneous pop: DEPTH = 2 full with A, B; valid_i = 1 with C, ready_i = 1.
  - That cycle: A popped, C not accepted.
  - Next cycle: ready_o = 1, usage_o = 1.
- Flush: DEPTH = 4 holding 2 entries, flush_i = 1 together with valid_i = 1.
  - Next cycle: valid_o = 0 and usage_o = 0; the pushed element is discarded.
  - DEPTH = 0 case: data_o, valid_o and ready_o mirror data_i, valid_i and ready_i combinationally.
